tnoc_vc_mux: RTL

- Merges CHANNELS per-virtual-channel flit streams onto one multi-VC flit link. It is the transmit-side counterpart of the VC demultiplexer.
- Sits at every router output port and at the network-interface egress.
- Internal ports: packet-atomic round-robin arbitration onto a single shared flit bus, followed by a one-entry output register slice.
- Local ports: per-channel flit buses, each with an independent one-entry register slice.

---
 rtl/tnoc_vc_mux_pkg.sv | 67 ++++++
 rtl/tnoc_vc_mux_slice.sv | 38 +++
 rtl/tnoc_vc_mux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tnoc_vc_mux_pkg.sv
// Shared types and helpers for the VC multiplexer: flit layout, network configuration,
// port-type selection and the round-robin grant function.
package tnoc_vc_mux_pkg;

  localparam int TNOC_DATA_W   = 16;
  localparam int TNOC_MAX_VC   = 8;
  localparam int TNOC_MAX_VC_W = 3;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [TNOC_DATA_W-1:0] data;
  } tnoc_flit;

  localparam int TNOC_FLIT_W = $bits(tnoc_flit);

  typedef struct packed {
    int virtual_channels;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

  typedef enum logic {
    TNOC_LOCAL_PORT    = 1'b0,
    TNOC_INTERNAL_PORT = 1'b1
  } tnoc_port_type;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } tnoc_arb_state_e;

  function automatic logic is_local_port(input tnoc_port_type port_type);
    return port_type == TNOC_LOCAL_PORT;
  endfunction

  function automatic logic is_head_flit(input tnoc_flit f);
    return f.head;
  endfunction

  function automatic logic is_tail_flit(input tnoc_flit f);
    return f.tail;
  endfunction

  // First requester at or after ptr, scanning upward and wrapping at n.
  function automatic logic [TNOC_MAX_VC-1:0] tnoc_rr_grant(
    input logic [TNOC_MAX_VC-1:0]   req,
    input logic [TNOC_MAX_VC_W-1:0] ptr,
    input int                       n
  );
    logic [TNOC_MAX_VC-1:0] grant;
    logic                   found;
    int                     idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < TNOC_MAX_VC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[idx[TNOC_MAX_VC_W-1:0]]) begin
        grant[idx[TNOC_MAX_VC_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/tnoc_vc_mux_slice.sv
// One-entry valid/ready register slice; the held entry stays stable until downstream takes it,
// and a new entry may load in the same cycle the old one leaves.
module tnoc_vc_mux_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_d = ready_o ? valid_i : valid_q;
  assign data_d  = (valid_i && ready_o) ? data_i : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tnoc_vc_mux.sv
// Merges per-VC flit streams onto one multi-VC link: independent per-VC slices on local
// ports, packet-atomic round-robin onto a shared bus plus one slice on internal ports.
module tnoc_vc_mux
  import tnoc_vc_mux_pkg::*;
#(
  parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
  parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT,
  localparam int CHANNELS = CONFIG.virtual_channels,
  localparam int OUT_W    = is_local_port(PORT_TYPE) ? CHANNELS * TNOC_FLIT_W : TNOC_FLIT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] flit_in_valid_i,
  output logic [CHANNELS-1:0] flit_in_ready_o,
  input  tnoc_flit            flit_in_flit_i [CHANNELS],
  output logic [CHANNELS-1:0] flit_in_vc_available_o,
  output logic [CHANNELS-1:0] flit_out_valid_o,
  input  logic [CHANNELS-1:0] flit_out_ready_i,
  output logic [OUT_W-1:0]    flit_out_flit_o,
  input  logic [CHANNELS-1:0] flit_out_vc_available_i
);

  assign flit_in_vc_available_o = flit_out_vc_available_i;

  if (is_local_port(PORT_TYPE)) begin : g_local
    for (genvar k = 0; k < CHANNELS; k++) begin : g_vc
      tnoc_vc_mux_slice #(
        .W (TNOC_FLIT_W)
      ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .valid_i (flit_in_valid_i[k]),
        .ready_o (flit_in_ready_o[k]),
        .data_i  (flit_in_flit_i[k]),
        .valid_o (flit_out_valid_o[k]),
        .ready_i (flit_out_ready_i[k]),
        .data_o  (flit_out_flit_o[k*TNOC_FLIT_W +: TNOC_FLIT_W])
      );
    end
  end else begin : g_internal
    localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    tnoc_arb_state_e     state_q;
    logic [VC_W-1:0]     ptr_q;
    logic [VC_W-1:0]     lock_vc_q;
    logic [VC_W-1:0]     gidx;
    logic [VC_W-1:0]     ptr_d;
    logic [CHANNELS-1:0] grant;
    logic                sel_valid;
    logic                can_load;
    logic                accept;
    tnoc_flit            sel_flit;
    logic                out_valid;
    logic [VC_W-1:0]     out_vc;
    tnoc_flit            out_flit;

    // While locked only the packet owner is granted, even if it is idling this cycle.
    always_comb begin
      grant = '0;
      if (state_q == ARB_LOCKED) begin
        grant[lock_vc_q] = 1'b1;
      end else begin
        grant = CHANNELS'(tnoc_rr_grant(TNOC_MAX_VC'(flit_in_valid_i),
                                        TNOC_MAX_VC_W'(ptr_q), CHANNELS));
      end
    end

    always_comb begin
      gidx = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (grant[k]) gidx = VC_W'(k);
      end
    end

    assign sel_flit  = flit_in_flit_i[gidx];
    assign sel_valid = |(grant & flit_in_valid_i);
    assign accept    = sel_valid && can_load;
    assign ptr_d     = (gidx == VC_W'(CHANNELS - 1)) ? '0 : gidx + VC_W'(1);
    assign flit_in_ready_o = grant & {CHANNELS{can_load}};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= ARB_IDLE;
        ptr_q     <= '0;
        lock_vc_q <= '0;
      end else begin
        case (state_q)
          ARB_IDLE: begin
            if (accept) begin
              ptr_q <= ptr_d;
              if (!is_tail_flit(sel_flit)) begin
                state_q   <= ARB_LOCKED;
                lock_vc_q <= gidx;
              end
            end
          end
          ARB_LOCKED: begin
            if (accept && is_tail_flit(sel_flit)) state_q <= ARB_IDLE;
          end
          default: state_q <= ARB_IDLE;
        endcase
      end
    end

    tnoc_vc_mux_slice #(
      .W (VC_W + TNOC_FLIT_W)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .valid_i (sel_valid),
      .ready_o (can_load),
      .data_i  ({gidx, sel_flit}),
      .valid_o (out_valid),
      .ready_i (flit_out_ready_i[out_vc]),
      .data_o  ({out_vc, out_flit})
    );

    always_comb begin
      flit_out_valid_o = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        flit_out_valid_o[k] = out_valid && (out_vc == VC_W'(k));
      end
    end

    assign flit_out_flit_o = out_flit;
  end

endmodule
